// File: rtl/regfile_wport_arb_if.sv
// Bus bundle between the pipeline and the register-file write-port arbiter:
// WB and MDU write streams, decode hazard query, RF write port and status.
interface regfile_wport_arb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic              wb_wen;
  logic [AW-1:0]     wb_waddr;
  logic [DW-1:0]     wb_wdata;
  logic              mdu_issue;
  logic [AW-1:0]     mdu_issue_rd;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [AW-1:0]     mdu_waddr;
  logic [DW-1:0]     mdu_wdata;
  logic              rf_wen;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_din;
  logic [AW-1:0]     dec_rs1;
  logic [AW-1:0]     dec_rs2;
  logic [AW-1:0]     dec_rd;
  logic              dec_rs1_use;
  logic              dec_rs2_use;
  logic              dec_rd_we;
  logic              hz_stall;
  logic              arb_hold;
  logic [2**AW-1:0]  busy_vec;

  modport master (
    output wb_wen, wb_waddr, wb_wdata,
    output mdu_issue, mdu_issue_rd, mdu_valid, mdu_waddr, mdu_wdata,
    output dec_rs1, dec_rs2, dec_rd, dec_rs1_use, dec_rs2_use, dec_rd_we,
    input  mdu_ready, rf_wen, rf_waddr, rf_din, hz_stall, arb_hold, busy_vec
  );

  modport slave (
    input  wb_wen, wb_waddr, wb_wdata,
    input  mdu_issue, mdu_issue_rd, mdu_valid, mdu_waddr, mdu_wdata,
    input  dec_rs1, dec_rs2, dec_rd, dec_rs1_use, dec_rs2_use, dec_rd_we,
    output mdu_ready, rf_wen, rf_waddr, rf_din, hz_stall, arb_hold, busy_vec
  );
endinterface

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: WB has priority, MDU results wait in a
// 2-entry FIFO, busy scoreboard drives hz_stall, starvation raises arb_hold.
// Optional perf counters are enabled with `define RF_ARB_PERF_EN.
module regfile_wport_arb #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wport_arb_if.slave   bus
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_hold_cnt
`endif
);

  localparam int NREG = 1 << AW;

  logic [AW-1:0]   fifo_addr_q [2];
  logic [DW-1:0]   fifo_data_q [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [3:0]      starve_q, starve_d;
  logic            hold_q, hold_d;

  logic            empty, full, push, drain;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;
  logic [NREG-1:0] drain_mask, ebusy;

  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign push      = bus.mdu_valid && !full;
  assign drain     = !bus.wb_wen && !empty;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign bus.mdu_ready = !full;
  assign bus.rf_wen    = bus.wb_wen | drain;
  assign bus.rf_waddr  = bus.wb_wen ? bus.wb_waddr : head_addr;
  assign bus.rf_din    = bus.wb_wen ? bus.wb_wdata : head_data;
  assign bus.arb_hold  = hold_q;
  assign bus.busy_vec  = busy_q;

  // The draining register is forwarded by the RF this cycle, so it no longer blocks decode.
  assign drain_mask = drain ? (NREG'(1) << head_addr) : '0;
  assign ebusy      = busy_q & ~drain_mask & ~NREG'(1);
  assign bus.hz_stall = (bus.dec_rs1_use & ebusy[bus.dec_rs1]) |
                        (bus.dec_rs2_use & ebusy[bus.dec_rs2]) |
                        (bus.dec_rd_we   & ebusy[bus.dec_rd]);

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ drain;
    wr_ptr_d = wr_ptr_q ^ push;
    unique case ({push, drain})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Clear first so that a same-cycle issue to the same register wins.
    busy_d = busy_q;
    if (drain) busy_d[head_addr] = 1'b0;
    if (bus.mdu_issue && (bus.mdu_issue_rd != '0)) busy_d[bus.mdu_issue_rd] = 1'b1;

    if (empty || drain)
      starve_d = 4'd0;
    else if (bus.wb_wen && (starve_q != 4'hF))
      starve_d = starve_q + 4'd1;
    else
      starve_d = starve_q;

    hold_d = !drain && (starve_d >= 4'(STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      busy_q   <= '0;
      starve_q <= 4'd0;
      hold_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  // FIFO payload carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.mdu_waddr;
      fifo_data_q[wr_ptr_q] <= bus.mdu_wdata;
    end
  end

`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_hold_q  <= 32'd0;
    end else begin
      if (bus.hz_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (hold_q)       perf_hold_q  <= perf_hold_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_hold_cnt  = perf_hold_q;
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_regfile_wport_arb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wport_arb_if #(.DW(DW), .AW(AW)) bus ();

`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_hold_cnt;
`endif

  regfile_wport_arb #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_hold_cnt  (perf_hold_cnt)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: pending MDU results in arrival order, per-register busy
  // flags, length of the current blocked-drain run and the hold flag.
  ent_t        mq[$];
  bit [31:0]   mbusy;
  int          mrun;
  bit          mhold;
  int unsigned m_stall_n, m_hold_n;

  int checks = 0;
  int errors = 0;

  function automatic bit m_drain();
    return !bus.wb_wen && (mq.size() != 0);
  endfunction

  function automatic bit m_ebusy(logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (m_drain() && mq[0].a == r) return 1'b0;
    return mbusy[r];
  endfunction

  function automatic bit m_stall();
    return (bus.dec_rs1_use && m_ebusy(bus.dec_rs1)) ||
           (bus.dec_rs2_use && m_ebusy(bus.dec_rs2)) ||
           (bus.dec_rd_we   && m_ebusy(bus.dec_rd));
  endfunction

  task automatic m_reset();
    mq.delete();
    mbusy = '0;
    mrun = 0;
    mhold = 1'b0;
    m_stall_n = 0;
    m_hold_n = 0;
  endtask

  task automatic idle();
    bus.wb_wen = 0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.mdu_issue = 0; bus.mdu_issue_rd = '0;
    bus.mdu_valid = 0; bus.mdu_waddr = '0; bus.mdu_wdata = '0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    bus.dec_rs1_use = 0; bus.dec_rs2_use = 0; bus.dec_rd_we = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the same edge.
  task automatic tick();
    bit   dr, pu, was_empty;
    ent_t hd, e;
    dr = m_drain();
    pu = bus.mdu_valid && (mq.size() < 2);
    was_empty = (mq.size() == 0);
    if (m_stall()) m_stall_n++;
    if (mhold) m_hold_n++;
    if (dr) begin
      hd = mq.pop_front();
      mbusy[hd.a] = 1'b0;
    end
    if (pu) begin
      e.a = bus.mdu_waddr;
      e.d = bus.mdu_wdata;
      mq.push_back(e);
    end
    if (bus.mdu_issue && bus.mdu_issue_rd != 0) mbusy[bus.mdu_issue_rd] = 1'b1;
    if (was_empty || dr) mrun = 0;
    else if (bus.wb_wen) mrun++;
    mhold = !dr && (mrun >= SM);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    bus.wb_wen = 1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h0BAD_F00D;
    bus.dec_rs1 = 5'd1; bus.dec_rs1_use = 1; bus.dec_rd = 5'd2; bus.dec_rd_we = 1;
    #2;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_mdu_ready got %b exp 1", bus.mdu_ready); end
    checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", bus.busy_vec); end
    checks++; if (bus.arb_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b exp 0", bus.arb_hold); end
    checks++; if (bus.hz_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.hz_stall); end
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd3) begin errors++; $display("FAIL reset_rf_follow got wen=%b addr=%0d exp 1/3", bus.rf_wen, bus.rf_waddr); end
    bus.wb_wen = 0;
    #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_idle got %b exp 0", bus.rf_wen); end
`ifdef RF_ARB_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_hold_cnt); end
`endif
    @(negedge clk);
    idle();
    rst = 1'b1;
    m_reset();
    tick();
  endtask

  task automatic test_passthrough();
    idle();
    bus.wb_wen = 1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hA5A5_A5A5;
    #2;
    checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL pass_wen got %b exp 1", bus.rf_wen); end
    checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL pass_addr got %0d exp 5", bus.rf_waddr); end
    checks++; if (bus.rf_din !== 32'hA5A5_A5A5) begin errors++; $display("FAIL pass_data got %h exp a5a5a5a5", bus.rf_din); end
    tick();
    idle();
  endtask

  task automatic test_hazard();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd7;
    #2; tick();
    bus.mdu_issue = 0;
    bus.dec_rs1 = 5'd7; bus.dec_rs1_use = 1;
    #2;
    checks++; if (bus.hz_stall !== 1'b1) begin errors++; $display("FAIL hazard_stall got %b exp 1", bus.hz_stall); end
    checks++; if (bus.busy_vec[7] !== 1'b1) begin errors++; $display("FAIL hazard_busy_set got %b exp 1", bus.busy_vec[7]); end
    bus.mdu_valid = 1; bus.mdu_waddr = 5'd7; bus.mdu_wdata = 32'h0000_1234;
    #1; tick();
    bus.mdu_valid = 0;
    #2;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd7) begin errors++; $display("FAIL hazard_drain_addr got wen=%b addr=%0d exp 1/7", bus.rf_wen, bus.rf_waddr); end
    checks++; if (bus.rf_din !== 32'h0000_1234) begin errors++; $display("FAIL hazard_drain_data got %h exp 00001234", bus.rf_din); end
    checks++; if (bus.hz_stall !== 1'b0) begin errors++; $display("FAIL hazard_masked got %b exp 0", bus.hz_stall); end
    checks++; if (bus.busy_vec[7] !== 1'b1) begin errors++; $display("FAIL hazard_busy_held got %b exp 1", bus.busy_vec[7]); end
    tick();
    #2;
    checks++; if (bus.busy_vec[7] !== 1'b0) begin errors++; $display("FAIL hazard_busy_clear got %b exp 0", bus.busy_vec[7]); end
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL hazard_idle got %b exp 0", bus.rf_wen); end
    tick();
    idle();
  endtask

  task automatic test_conflict();
    idle();
    bus.wb_wen = 1; bus.wb_waddr = 5'd1; bus.wb_wdata = 32'h1111_1111;
    bus.mdu_valid = 1; bus.mdu_waddr = 5'd3; bus.mdu_wdata = 32'h3333_3333;
    #2;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready0 got %b exp 1", bus.mdu_ready); end
    tick();
    bus.mdu_waddr = 5'd4; bus.mdu_wdata = 32'h4444_4444;
    #2;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready1 got %b exp 1", bus.mdu_ready); end
    tick();
    bus.mdu_valid = 0;
    #2;
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL conflict_full got %b exp 0", bus.mdu_ready); end
    checks++; if (bus.rf_waddr !== 5'd1) begin errors++; $display("FAIL conflict_wb_prio got %0d exp 1", bus.rf_waddr); end
    tick();
    bus.wb_wen = 0;
    #2;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_din !== 32'h3333_3333) begin errors++; $display("FAIL conflict_first got wen=%b addr=%0d data=%h exp 1/3/33333333", bus.rf_wen, bus.rf_waddr, bus.rf_din); end
    tick();
    #2;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_din !== 32'h4444_4444) begin errors++; $display("FAIL conflict_second got wen=%b addr=%0d data=%h exp 1/4/44444444", bus.rf_wen, bus.rf_waddr, bus.rf_din); end
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready_back got %b exp 1", bus.mdu_ready); end
    tick();
    #2;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL conflict_empty got %b exp 0", bus.rf_wen); end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    idle();
    bus.wb_wen = 1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h2222_2222;
    bus.mdu_valid = 1; bus.mdu_waddr = 5'd10; bus.mdu_wdata = 32'h0000_BEEF;
    #2; tick();
    bus.mdu_valid = 0;
    for (int i = 1; i <= SM; i++) begin
      #2;
      checks++; if (bus.arb_hold !== 1'b0) begin errors++; $display("FAIL starve_early cycle %0d got %b exp 0", i, bus.arb_hold); end
      tick();
    end
    #2;
    checks++; if (bus.arb_hold !== 1'b1) begin errors++; $display("FAIL starve_hold_rise got %b exp 1", bus.arb_hold); end
    tick();
    bus.wb_wen = 0;
    #2;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_din !== 32'h0000_BEEF) begin errors++; $display("FAIL starve_drain got wen=%b addr=%0d data=%h exp 1/10/0000beef", bus.rf_wen, bus.rf_waddr, bus.rf_din); end
    checks++; if (bus.arb_hold !== 1'b1) begin errors++; $display("FAIL starve_hold_during_drain got %b exp 1", bus.arb_hold); end
    tick();
    #2;
    checks++; if (bus.arb_hold !== 1'b0) begin errors++; $display("FAIL starve_hold_clear got %b exp 0", bus.arb_hold); end
    tick();
    idle();
  endtask

  task automatic test_collision();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd9;
    #2; tick();
    bus.mdu_issue = 0;
    bus.wb_wen = 1; bus.wb_waddr = 5'd6; bus.wb_wdata = 32'h6;
    bus.mdu_valid = 1; bus.mdu_waddr = 5'd9; bus.mdu_wdata = 32'h9999_0009;
    #2; tick();
    bus.mdu_valid = 0;
    bus.wb_wen = 0;
    bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd9;
    #2;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd9) begin errors++; $display("FAIL collide_drain got wen=%b addr=%0d exp 1/9", bus.rf_wen, bus.rf_waddr); end
    tick();
    bus.mdu_issue = 0;
    #2;
    checks++; if (bus.busy_vec[9] !== 1'b1) begin errors++; $display("FAIL collide_set_wins got %b exp 1", bus.busy_vec[9]); end
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    bus.wb_wen = 1; bus.wb_waddr = 5'd8; bus.wb_wdata = 32'h8;
    bus.mdu_valid = 1; bus.mdu_waddr = 5'd12; bus.mdu_wdata = 32'hC;
    bus.mdu_issue = 1; bus.mdu_issue_rd = 5'd12;
    #2; tick();
    bus.mdu_waddr = 5'd13; bus.mdu_issue_rd = 5'd13;
    #2; tick();
    bus.mdu_valid = 0; bus.mdu_issue = 0;
    for (int i = 0; i < SM; i++) tick();
    #2;
    checks++; if (bus.arb_hold !== mhold || bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL areset_pre got hold=%b ready=%b exp %b/0", bus.arb_hold, bus.mdu_ready, mhold); end
    checks++; if (bus.busy_vec !== mbusy) begin errors++; $display("FAIL areset_pre_busy got %h exp %h", bus.busy_vec, mbusy); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", bus.mdu_ready); end
    checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL areset_busy got %h exp 0", bus.busy_vec); end
    checks++; if (bus.arb_hold !== 1'b0) begin errors++; $display("FAIL areset_hold got %b exp 0", bus.arb_hold); end
`ifdef RF_ARB_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin errors++; $display("FAIL areset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_hold_cnt); end
`endif
    @(negedge clk);
    idle();
    rst = 1'b1;
    m_reset();
    tick();
    #2;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL areset_fifo_flushed got %b exp 0", bus.rf_wen); end
    tick();
  endtask

  task automatic test_random();
    bit            ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    for (int c = 0; c < 600; c++) begin
      bus.wb_wen       = mhold ? 1'b0 : ($urandom_range(0, 99) < 55);
      bus.wb_waddr     = AW'($urandom_range(0, 31));
      bus.wb_wdata     = $urandom;
      bus.mdu_valid    = ($urandom_range(0, 99) < 40);
      bus.mdu_waddr    = AW'($urandom_range(0, 31));
      bus.mdu_wdata    = $urandom;
      bus.mdu_issue    = ($urandom_range(0, 99) < 30);
      bus.mdu_issue_rd = AW'($urandom_range(0, 31));
      bus.dec_rs1      = AW'($urandom_range(0, 31));
      bus.dec_rs2      = AW'($urandom_range(0, 31));
      bus.dec_rd       = AW'($urandom_range(0, 31));
      bus.dec_rs1_use  = $urandom_range(0, 1);
      bus.dec_rs2_use  = $urandom_range(0, 1);
      bus.dec_rd_we    = $urandom_range(0, 1);
      #2;
      ewen  = bus.wb_wen || m_drain();
      eaddr = bus.wb_wen ? bus.wb_waddr : (m_drain() ? mq[0].a : '0);
      edata = bus.wb_wen ? bus.wb_wdata : (m_drain() ? mq[0].d : '0);
      checks++; if (bus.mdu_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, bus.mdu_ready, mq.size() < 2); end
      checks++; if (bus.rf_wen !== ewen) begin errors++; $display("FAIL rand_wen cyc %0d got %b exp %b", c, bus.rf_wen, ewen); end
      if (ewen) begin
        checks++; if (bus.rf_waddr !== eaddr || bus.rf_din !== edata) begin errors++; $display("FAIL rand_port cyc %0d got %0d/%h exp %0d/%h", c, bus.rf_waddr, bus.rf_din, eaddr, edata); end
      end
      checks++; if (bus.hz_stall !== m_stall()) begin errors++; $display("FAIL rand_stall cyc %0d got %b exp %b", c, bus.hz_stall, m_stall()); end
      checks++; if (bus.arb_hold !== mhold) begin errors++; $display("FAIL rand_hold cyc %0d got %b exp %b", c, bus.arb_hold, mhold); end
      checks++; if (bus.busy_vec !== mbusy) begin errors++; $display("FAIL rand_busy cyc %0d got %h exp %h", c, bus.busy_vec, mbusy); end
`ifdef RF_ARB_PERF_EN
      checks++; if (perf_stall_cnt !== m_stall_n || perf_hold_cnt !== m_hold_n) begin errors++; $display("FAIL rand_perf cyc %0d got %0d/%0d exp %0d/%0d", c, perf_stall_cnt, perf_hold_cnt, m_stall_n, m_hold_n); end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_passthrough();
    test_hazard();
    test_conflict();
    test_starvation();
    test_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
